// File: rtl/serial_adder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : serial_adder_pkg
// Description : Shared definitions for the bit-serial adder controller:
//               controller state encoding and the counter-width helper.
// Revision    : 1.0 - initial release
// ============================================================================
package serial_adder_pkg;

    // Controller states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Bit counter must reach WIDTH-1; a 1-bit operand still needs a
    // one-bit counter, so the width never drops below 1.
    function automatic int cnt_width(input int width);
        if (width <= 1) begin
            return 1;
        end
        return $clog2(width);
    endfunction

endpackage : serial_adder_pkg
`default_nettype wire

// File: rtl/serial_adder_ctrl_fa.sv
`default_nettype none
// ============================================================================
// Module      : FA
// Description : Single-bit full adder, the only arithmetic element of the
//               bit-serial adder.
// Ports       : a, b, cin  - addend bits and carry in
//               sum, cout  - sum bit and carry out
// Revision    : 1.0 - initial release
// ============================================================================
module FA (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));

endmodule : FA
`default_nettype wire

// File: rtl/serial_adder_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : serial_adder_ctrl
// Description : Bit-serial adder controller. Loads a WIDTH-bit operand pair
//               on start, feeds one bit per clock (LSB first) through a
//               single full adder with a registered carry, and presents the
//               result with a one-cycle done pulse.
// Ports       : clk, rst (async, active high)
//               start        - load request, honoured in IDLE or DONE
//               a, b         - operands, sampled with start
//               sub          - subtract select (only with SERIAL_ADDER_SUB_EN)
//               busy         - high while the operation is running
//               done         - one-cycle result-valid pulse
//               sum, cout    - result, held until the next completion
// Config      : `define SERIAL_ADDER_SUB_EN adds the sub port and a-b mode
// Revision    : 1.0 - initial release
// ============================================================================
module serial_adder_ctrl
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int                 c_cnt_w    = cnt_width(WIDTH);
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(WIDTH - 1);

    state_t             r_state;
    logic [WIDTH-1:0]   r_a_sr;
    logic [WIDTH-1:0]   r_b_sr;
    logic [WIDTH-1:0]   r_sum_sr;
    logic               r_carry;
    logic [c_cnt_w-1:0] r_cnt;

    logic               w_fa_sum;
    logic               w_fa_cout;
    logic [WIDTH-1:0]   w_sum_next;

    FA u_fa (
        .a    (r_a_sr[0]),
        .b    (r_b_sr[0]),
        .cin  (r_carry),
        .sum  (w_fa_sum),
        .cout (w_fa_cout)
    );

    // New sum bit enters at the MSB; after WIDTH shifts bit 0 sits at the LSB.
    // Written as shift/or so that WIDTH=1 needs no special-case slicing.
    assign w_sum_next = (r_sum_sr >> 1) | (WIDTH'(w_fa_sum) << (WIDTH - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= IDLE;
            r_a_sr   <= '0;
            r_b_sr   <= '0;
            r_sum_sr <= '0;
            r_carry  <= 1'b0;
            r_cnt    <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            sum      <= '0;
            cout     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (r_state)
                IDLE, DONE: begin
                    // DONE accepts start directly so operations can run
                    // back-to-back without an IDLE bubble.
                    if (start) begin
                        r_a_sr   <= a;
                        r_sum_sr <= '0;
                        r_cnt    <= '0;
`ifdef SERIAL_ADDER_SUB_EN
                        // Two's-complement subtract: a + ~b + 1
                        r_b_sr   <= sub ? ~b : b;
                        r_carry  <= sub;
`else
                        r_b_sr   <= b;
                        r_carry  <= 1'b0;
`endif
                        busy     <= 1'b1;
                        r_state  <= RUN;
                    end else begin
                        r_state  <= IDLE;
                    end
                end

                RUN: begin
                    r_a_sr   <= r_a_sr >> 1;
                    r_b_sr   <= r_b_sr >> 1;
                    r_sum_sr <= w_sum_next;
                    r_carry  <= w_fa_cout;
                    r_cnt    <= r_cnt + 1'b1;
                    if (r_cnt == c_cnt_last) begin
                        sum     <= w_sum_next;
                        cout    <= w_fa_cout;
                        done    <= 1'b1;
                        busy    <= 1'b0;
                        r_state <= DONE;
                    end
                end

                default: begin
                    busy    <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule : serial_adder_ctrl
`default_nettype wire

// File: tb/tb_serial_adder_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_serial_adder_ctrl
// Description : Directed self-checking bench for serial_adder_ctrl with an
//               8-bit and a 1-bit instance. Subtract cases are built only
//               when SERIAL_ADDER_SUB_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_adder_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;

    logic       start8 = 1'b0;
    logic [7:0] a8 = '0;
    logic [7:0] b8 = '0;
    logic       sub8 = 1'b0;
    logic       busy8, done8, cout8;
    logic [7:0] sum8;

    logic       start1 = 1'b0;
    logic [0:0] a1 = '0;
    logic [0:0] b1 = '0;
    logic       sub1 = 1'b0;
    logic       busy1, done1, cout1;
    logic [0:0] sum1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    serial_adder_ctrl #(.WIDTH(8)) dut8 (
        .clk   (clk),
        .rst   (rst),
        .start (start8),
        .a     (a8),
        .b     (b8),
`ifdef SERIAL_ADDER_SUB_EN
        .sub   (sub8),
`endif
        .busy  (busy8),
        .done  (done8),
        .sum   (sum8),
        .cout  (cout8)
    );

    serial_adder_ctrl #(.WIDTH(1)) dut1 (
        .clk   (clk),
        .rst   (rst),
        .start (start1),
        .a     (a1),
        .b     (b1),
`ifdef SERIAL_ADDER_SUB_EN
        .sub   (sub1),
`endif
        .busy  (busy1),
        .done  (done1),
        .sum   (sum1),
        .cout  (cout1)
    );

    // ------------------------------------------------------------------
    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({busy8, done8, cout8, sum8} !== 11'd0) begin
            errors++;
            $display("FAIL reset8 got %b exp %b", {busy8, done8, cout8, sum8}, 11'd0);
        end
        checks++;
        if ({busy1, done1, cout1, sum1} !== 4'd0) begin
            errors++;
            $display("FAIL reset1 got %b exp %b", {busy1, done1, cout1, sum1}, 4'd0);
        end
        rst = 1'b0;
    endtask

    // 0x5A + 0x3C = 0x096; busy for 8 cycles, done 8 cycles after start
    task automatic test_basic_add();
        @(posedge clk); #1;
        a8 = 8'h5A; b8 = 8'h3C; sub8 = 1'b0; start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        for (int i = 0; i < 8; i++) begin
            checks++;
            if ({busy8, done8} !== 2'b10) begin
                errors++;
                $display("FAIL basic_busy cyc %0d got busy,done=%b exp 10", i, {busy8, done8});
            end
            @(posedge clk); #1;
        end
        checks++;
        if ({busy8, done8, cout8, sum8} !== {2'b01, 1'b0, 8'h96}) begin
            errors++;
            $display("FAIL basic_result got b,d,c,s=%b exp %b",
                     {busy8, done8, cout8, sum8}, {2'b01, 1'b0, 8'h96});
        end
        @(posedge clk); #1;
        checks++;
        if ({busy8, done8, cout8, sum8} !== {2'b00, 1'b0, 8'h96}) begin
            errors++;
            $display("FAIL basic_hold got b,d,c,s=%b exp %b",
                     {busy8, done8, cout8, sum8}, {2'b00, 1'b0, 8'h96});
        end
    endtask

    // 0xFF + 0x01 = 0x100, then restart from DONE: 0x01 + 0x01 = 0x002
    task automatic test_back_to_back();
        @(posedge clk); #1;
        a8 = 8'hFF; b8 = 8'h01; start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        checks++;
        if ({done8, cout8, sum8} !== {1'b1, 1'b1, 8'h00}) begin
            errors++;
            $display("FAIL b2b_first got d,c,s=%b exp %b", {done8, cout8, sum8}, {2'b11, 8'h00});
        end
        a8 = 8'h01; b8 = 8'h01; start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        checks++;
        if ({busy8, done8, cout8, sum8} !== {2'b10, 1'b1, 8'h00}) begin
            errors++;
            $display("FAIL b2b_reload got b,d,c,s=%b exp %b",
                     {busy8, done8, cout8, sum8}, {2'b10, 1'b1, 8'h00});
        end
        repeat (7) @(posedge clk);
        #1;
        checks++;
        if ({busy8, done8} !== 2'b10) begin
            errors++;
            $display("FAIL b2b_early got busy,done=%b exp 10", {busy8, done8});
        end
        @(posedge clk); #1;
        checks++;
        if ({busy8, done8, cout8, sum8} !== {2'b01, 1'b0, 8'h02}) begin
            errors++;
            $display("FAIL b2b_second got b,d,c,s=%b exp %b",
                     {busy8, done8, cout8, sum8}, {2'b01, 1'b0, 8'h02});
        end
    endtask

    // start held through RUN while a/b wander: result uses loaded values
    task automatic test_start_held();
        @(posedge clk); #1;
        a8 = 8'h0F; b8 = 8'h0F; start8 = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 8; i++) begin
            checks++;
            if ({busy8, done8} !== 2'b10) begin
                errors++;
                $display("FAIL held_busy cyc %0d got busy,done=%b exp 10", i, {busy8, done8});
            end
            a8 = 8'hF0 ^ 8'(i);
            b8 = 8'hC3 + 8'(i * 7);
            @(posedge clk); #1;
        end
        checks++;
        if ({done8, cout8, sum8} !== {1'b1, 1'b0, 8'h1E}) begin
            errors++;
            $display("FAIL held_result got d,c,s=%b exp %b", {done8, cout8, sum8}, {2'b10, 8'h1E});
        end
        // start still high in DONE: this reloads with 0x80 + 0x80
        a8 = 8'h80; b8 = 8'h80;
        @(posedge clk); #1;
        start8 = 1'b0;
        checks++;
        if ({busy8, done8, sum8} !== {2'b10, 8'h1E}) begin
            errors++;
            $display("FAIL held_restart got b,d,s=%b exp %b", {busy8, done8, sum8}, {2'b10, 8'h1E});
        end
        repeat (8) @(posedge clk);
        #1;
        checks++;
        if ({done8, cout8, sum8} !== {1'b1, 1'b1, 8'h00}) begin
            errors++;
            $display("FAIL held_second got d,c,s=%b exp %b", {done8, cout8, sum8}, {2'b11, 8'h00});
        end
    endtask

    // async reset after the 3rd RUN cycle, then 0x12 + 0x34 = 0x46
    task automatic test_reset_midrun();
        int done_seen;
        int waited;
        @(posedge clk); #1;
        a8 = 8'hAA; b8 = 8'h55; start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        repeat (3) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        checks++;
        if ({busy8, done8, cout8, sum8} !== 11'd0) begin
            errors++;
            $display("FAIL midrun_async got b,d,c,s=%b exp %b", {busy8, done8, cout8, sum8}, 11'd0);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        done_seen = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (done8 === 1'b1) done_seen++;
        end
        checks++;
        if (done_seen !== 0) begin
            errors++;
            $display("FAIL midrun_nodone got %0d done pulses exp 0", done_seen);
        end
        a8 = 8'h12; b8 = 8'h34; start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        waited = 0;
        while (done8 !== 1'b1 && waited < 20) begin
            @(posedge clk); #1;
            waited++;
        end
        checks++;
        if (waited !== 8) begin
            errors++;
            $display("FAIL midrun_latency got %0d cycles exp 8", waited);
        end
        checks++;
        if ({cout8, sum8} !== {1'b0, 8'h46}) begin
            errors++;
            $display("FAIL midrun_result got c,s=%b exp %b", {cout8, sum8}, {1'b0, 8'h46});
        end
    endtask

    // WIDTH=1: one RUN cycle, {cout,sum} follows the full-adder truth table
    task automatic test_width1();
        logic [1:0] add_tab [4] = '{2'd0, 2'd1, 2'd1, 2'd2};
        logic [1:0] sub_tab [4] = '{2'd2, 2'd1, 2'd3, 2'd2};
        logic [1:0] ab;
        int         nmodes;
`ifdef SERIAL_ADDER_SUB_EN
        nmodes = 2;
`else
        nmodes = 1;
`endif
        @(posedge clk); #1;
        for (int m = 0; m < nmodes; m++) begin
            for (int idx = 0; idx < 4; idx++) begin
                ab = idx[1:0];
                a1 = ab[1]; b1 = ab[0]; sub1 = (m == 1); start1 = 1'b1;
                @(posedge clk); #1;
                start1 = 1'b0;
                checks++;
                if ({busy1, done1} !== 2'b10) begin
                    errors++;
                    $display("FAIL w1_busy m%0d ab=%b got busy,done=%b exp 10", m, ab, {busy1, done1});
                end
                @(posedge clk); #1;
                checks++;
                if ({busy1, done1, cout1, sum1} !== {2'b01, (m == 1) ? sub_tab[idx] : add_tab[idx]}) begin
                    errors++;
                    $display("FAIL w1_result m%0d ab=%b got b,d,c,s=%b exp %b", m, ab,
                             {busy1, done1, cout1, sum1},
                             {2'b01, (m == 1) ? sub_tab[idx] : add_tab[idx]});
                end
            end
        end
    endtask

`ifdef SERIAL_ADDER_SUB_EN
    // 0x10 - 0x01 = 0x0F (no borrow); 0x00 - 0x01 = 0xFF (borrow)
    task automatic test_subtract();
        logic [7:0] ta [2] = '{8'h10, 8'h00};
        logic [7:0] tb [2] = '{8'h01, 8'h01};
        logic [8:0] te [2] = '{{1'b1, 8'h0F}, {1'b0, 8'hFF}};
        for (int t = 0; t < 2; t++) begin
            @(posedge clk); #1;
            a8 = ta[t]; b8 = tb[t]; sub8 = 1'b1; start8 = 1'b1;
            @(posedge clk); #1;
            start8 = 1'b0; sub8 = 1'b0;
            repeat (8) @(posedge clk);
            #1;
            checks++;
            if ({done8, cout8, sum8} !== {1'b1, te[t]}) begin
                errors++;
                $display("FAIL sub_%0d got d,c,s=%b exp %b", t, {done8, cout8, sum8}, {1'b1, te[t]});
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_basic_add();
        test_back_to_back();
        test_start_held();
        test_reset_midrun();
        test_width1();
`ifdef SERIAL_ADDER_SUB_EN
        test_subtract();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Global time bound so the run cannot hang
    initial begin
        #200000;
        $display("FAIL timeout got no finish exp finish");
        $fatal(1, "timeout");
    end

endmodule : tb_serial_adder_ctrl
`default_nettype wire

// File: doc/serial_adder_ctrl.md
# serial_adder_ctrl

Bit-serial adder controller that sequences the team's single-bit `FA` full adder over a WIDTH-bit operand pair, one bit per clock, LSB first. It loads the operands on a start pulse, runs the `FA` for WIDTH cycles with a registered carry, and presents the result with a one-cycle done pulse. It is the minimum-area alternative to a ripple-carry adder wherever throughput of one add per WIDTH+1 cycles is acceptable.

## Interface
- WIDTH, 8, operand and result width in bits (≥1)
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  request; sampled only in IDLE or DONE
- a  in  WIDTH  operand A, sampled with start
- b  in  WIDTH  operand B, sampled with start
- sub  in  1  subtract select, sampled with start (present only with SERIAL_ADDER_SUB_EN)
- busy  out  1  high while in RUN
- done  out  1  one-cycle pulse: result valid
- sum  out  WIDTH  result, held until next completion
- cout  out  1  final carry, held with sum

## Operation
- States:
  - IDLE: start=1 → load a_sr←a, b_sr←b, carry←0, cnt←0 → RUN.
  - RUN: `FA` inputs are a_sr[0], b_sr[0], carry. Its sum bit shifts into the MSB of sum_sr (right shift). carry←FA cout. a_sr and b_sr shift right. cnt++. When cnt==WIDTH-1 → DONE, with sum←final sum_sr and cout←final carry.
  - DONE: done=1. start=1 → reload as in IDLE → RUN (back-to-back). Otherwise → IDLE.
- start while in RUN is ignored; no queueing.
- Inputs a/b change after load: no effect on the operation in flight.
- Arithmetic: {cout,sum} = a + b, modulo 2^(WIDTH+1); no overflow flag.
- cnt width is clog2(WIDTH), minimum 1. WIDTH=1 gives exactly one RUN cycle.
- Reset (any time, including mid-RUN): state=IDLE, busy=0, done=0, sum=0, cout=0, carry=0, internal shift registers=0. The interrupted operation is lost and produces no done.

## Timing
- start sampled high at edge k → busy=1 after edge k.
- Bits 0..WIDTH-1 are processed at edges k+1..k+WIDTH.
- sum, cout and done update at edge k+WIDTH. done is high for exactly one cycle; busy drops at the same edge.
- Latency start→done: WIDTH cycles. Peak throughput: one operation per WIDTH+1 cycles.
- sum/cout change only at a completion edge or on reset.

## Configuration
- SERIAL_ADDER_SUB_EN defined:
  - The sub port exists.
  - sub=1 at load stores b_sr←~b and carry←1, giving {cout,sum} = a + ~b + 1. cout=1 means no borrow.
  - sub=0 behaves as add.
- SERIAL_ADDER_SUB_EN undefined:
  - There is no sub port and no inversion logic.
  - The block is add-only.

## Structure
- Package serial_adder_pkg holds:
  - state encodings IDLE=2'd0, RUN=2'd1, DONE=2'd2
  - the counter-width helper function
- One sub-module: the existing `FA` (ports a, b, cin, sum, cout) as the sole arithmetic element.
- All sequencing, shift registers and the carry flop live in serial_adder_ctrl.

## Test plan
- WIDTH=8, a=0x5A, b=0x3C, start pulse → done exactly 8 cycles later; sum=0x96, cout=0; busy high for 8 cycles.
- a=0xFF, b=0x01 → sum=0x00, cout=1. Then a second start in the DONE cycle with a=0x01, b=0x01 → sum=0x02, cout=0, with no IDLE cycle in between.
- start held high throughout RUN with a/b changing each cycle → result matches the originally loaded operands; a new operation starts only from DONE.
- rst asserted asynchronously after the 3rd RUN cycle → all outputs 0 immediately with no done. A following a=0x12, b=0x34 gives sum=0x46.
- WIDTH=1, all 8 (a,b,cin-equivalent) combinations via add and, with the macro, sub → {cout,sum} matches the `FA` truth table, including 1+1 → sum=0, cout=1.
- SERIAL_ADDER_SUB_EN defined, sub=1:
  - a=0x10, b=0x01 → sum=0x0F, cout=1.
  - a=0x00, b=0x01 → sum=0xFF, cout=0.
